mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single data port of the 64-bit unified memory between two requesters:
  - the CPU load/store unit;
  - a UART boot loader that packs received bytes into doublewords and stores them at consecutive addresses.
- Sits between the CPU/UART receiver and the memory's dataadr/writedata/memwrite/memread/dword inputs.
- Memory readdata is registered, so it arrives one cycle after memread.

Parameters:
- N, 64, data/address width.
- LOAD_BASE, 0, byte address of the first loader doubleword (multiple of 8).
- STARVE_LIMIT, 4, cycles a pending loader write may lose arbitration before it gets priority.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  2  store size: 3=D, 2=B, 1=W; 0 means load
- cpu_dword  in  1  load width: 1=doubleword, 0=word
- cpu_adr  in  N  CPU byte address
- cpu_wdata  in  N  CPU store data
- cpu_ack  out  1  one-cycle pulse: request issued to memory
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  N  load data (pass-through of mem_readdata)
- ld_en  in  1  loader enable
- rx_valid  in  1  one-cycle strobe with rx_byte
- rx_byte  in  8  received byte
- ld_count  out  16  doublewords written since reset or ld_en rise
- ld_overflow  out  1  sticky: byte dropped
- mem_adr  out  N  to memory dataadr
- mem_wdata  out  N  to memory writedata
- mem_memwrite  out  2  to memory memwrite
- mem_memread  out  1  to memory memread
- mem_dword  out  1  to memory dword
- mem_readdata  in  N  from memory readdata

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Loader address = LOAD_BASE.
  - Byte count, pending flags and starvation counter cleared.
- All mem_* outputs are registered. They are non-zero only in the single ISSUE cycle, except mem_adr and mem_wdata, which hold their last value.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE arbitration:
  - Loader wins if ld_pend and starve_cnt >= STARVE_LIMIT.
  - Otherwise the CPU wins if cpu_req.
  - Otherwise the loader wins if ld_pend.
  - Winner's command is registered to mem_*; go to ISSUE.
- ISSUE:
  - CPU write: cpu_ack=1; next state IDLE.
  - CPU read (cpu_we=0): mem_memread=1, mem_dword=cpu_dword; cpu_ack=1; next state RDWAIT.
  - Loader write: mem_memwrite=3, mem_adr=ld_adr; ld_pend cleared; ld_adr += 8; ld_count += 1; next state IDLE.
- RDWAIT:
  - cpu_rvalid=1, cpu_rdata=mem_readdata; next state IDLE.
- CPU timing:
  - Store: cpu_req seen in cycle 0, ack in cycle 1.
  - Load: ack in cycle 1, rvalid in cycle 2.
  - Minimum gap between successive CPU issues: 2 cycles (write) or 3 cycles (read).
- cpu_req must stay stable until cpu_ack. Changes before cpu_ack are undefined.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle ld_pend=1 and the loader is not in ISSUE.
  - Clears on loader ISSUE.
- Loader byte packing:
  - When ld_en=1 and rx_valid=1, the byte shifts into a 64-bit assembler, big-endian: first byte lands in [63:56].
  - byte_cnt 0..7. On the 8th byte, if ld_pend=0, the assembled word moves to the holding register, ld_pend=1 and byte_cnt=0.
  - If ld_pend=1 when the 8th byte arrives, that byte is dropped, byte_cnt stays 7 and ld_overflow is set.
  - A holding-register transfer and a loader ISSUE in the same cycle are allowed; the new word is pending next cycle.
- ld_en control:
  - ld_en=0: rx_valid is ignored and byte_cnt is cleared (partial word discarded). A word already pending is still written.
  - Rising edge of ld_en: ld_adr=LOAD_BASE, ld_count=0, ld_overflow=0.
- ld_adr wraps modulo 2^N. ld_count wraps at 16 bits.
- Reset mid-operation: an in-flight read's rvalid is not produced; the pending word is lost.

Optional Feature:
- Macro: MEM_PORT_ARBITER_CHECKSUM_EN.
- When defined:
  - Adds output ld_csum [N-1:0]: XOR of every doubleword the loader writes to memory.
  - Cleared by reset and by the ld_en rising edge; updated in the loader ISSUE cycle.
- When undefined: the port and its logic are absent.

Test Plan:
- CPU store D: cpu_we=3, adr=0x10, wdata=0x1122334455667788 -> cycle 1: mem_memwrite=3, mem_adr=0x10, cpu_ack=1.
- CPU load W: cpu_we=0, cpu_dword=0, adr=0x14, mem_readdata=0xAABBCCDD returned -> ack in cycle 1; cycle 2: cpu_rvalid=1, cpu_rdata=0xAABBCCDD.
- Loader with ld_en=1: bytes 01..08 -> mem_memwrite=3, mem_adr=LOAD_BASE, mem_wdata=0x0102030405060708, ld_count=1; next word goes to LOAD_BASE+8.
- Starvation: cpu_req held continuously with a loader word pending -> loader ISSUE occurs within STARVE_LIMIT+3 cycles; CPU is served afterwards.
- Overflow: cpu_req held continuously, STARVE_LIMIT=15, 16 bytes sent back-to-back -> 16th byte dropped, ld_overflow=1; first pending word still written.
- ld_en dropped after 3 bytes, then raised, then 8 bytes sent -> written word is made of the new 8 bytes only, at LOAD_BASE; ld_count=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory data port between the CPU load/store unit and the UART boot loader.
// Define MEM_PORT_ARBITER_CHECKSUM_EN to add ld_csum, the XOR of every loader-written doubleword.
module mem_port_arbiter #(
    parameter int unsigned  N            = 64,
    parameter logic [N-1:0] LOAD_BASE    = '0,
    parameter int unsigned  STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic [1:0]   cpu_we,
    input  logic         cpu_dword,
    input  logic [N-1:0] cpu_adr,
    input  logic [N-1:0] cpu_wdata,
    output logic         cpu_ack,
    output logic         cpu_rvalid,
    output logic [N-1:0] cpu_rdata,
    input  logic         ld_en,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    output logic [15:0]  ld_count,
    output logic         ld_overflow,
`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
    output logic [N-1:0] ld_csum,
`endif
    output logic [N-1:0] mem_adr,
    output logic [N-1:0] mem_wdata,
    output logic [1:0]   mem_memwrite,
    output logic         mem_memread,
    output logic         mem_dword,
    input  logic [N-1:0] mem_readdata
);
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t        state, state_nx;
    logic          grant_cpu, grant_ld;
    logic          owner_ld, issue_rd;
    logic          ld_en_q, ld_rise, ld_issue;
    logic          ld_pend;
    logic          byte_in, last_byte, xfer, drop;
    logic [2:0]    byte_cnt;
    logic [N-1:0]  ld_asm, asm_nx, ld_hold, ld_adr;
    logic [SW-1:0] starve_cnt;

    assign ld_rise   = ld_en & ~ld_en_q;
    assign ld_issue  = (state == ISSUE) && owner_ld;
    assign byte_in   = ld_en & rx_valid;
    assign last_byte = byte_in && (byte_cnt == 3'd7);
    // The holding register frees up in the loader's own ISSUE cycle, so a word can move in then.
    assign xfer      = last_byte && (!ld_pend || ld_issue);
    assign drop      = last_byte && ld_pend && !ld_issue;
    assign asm_nx    = {ld_asm[N-9:0], rx_byte};
    assign cpu_rdata = cpu_rvalid ? mem_readdata : '0;

    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_pend && (starve_cnt >= STARVE_MAX)) grant_ld = 1'b1;
                else if (cpu_req)                          grant_cpu = 1'b1;
                else if (ld_pend)                          grant_ld = 1'b1;
                if (grant_cpu || grant_ld) state_nx = ISSUE;
            end
            ISSUE:   state_nx = (!owner_ld && issue_rd) ? RDWAIT : IDLE;
            RDWAIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner_ld     <= 1'b0;
            issue_rd     <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rvalid   <= 1'b0;
            mem_adr      <= '0;
            mem_wdata    <= '0;
            mem_memwrite <= '0;
            mem_memread  <= 1'b0;
            mem_dword    <= 1'b0;
        end else begin
            state        <= state_nx;
            cpu_ack      <= grant_cpu;
            cpu_rvalid   <= (state == ISSUE) && !owner_ld && issue_rd;
            mem_memread  <= grant_cpu && (cpu_we == 2'd0);
            mem_dword    <= grant_cpu && (cpu_we == 2'd0) && cpu_dword;
            mem_memwrite <= grant_cpu ? cpu_we : (grant_ld ? 2'd3 : 2'd0);
            if (grant_cpu) begin
                owner_ld  <= 1'b0;
                issue_rd  <= (cpu_we == 2'd0);
                mem_adr   <= cpu_adr;
                mem_wdata <= cpu_wdata;
            end else if (grant_ld) begin
                owner_ld  <= 1'b1;
                issue_rd  <= 1'b0;
                mem_adr   <= ld_adr;
                mem_wdata <= ld_hold;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_en_q     <= 1'b0;
            byte_cnt    <= '0;
            ld_asm      <= '0;
            ld_hold     <= '0;
            ld_pend     <= 1'b0;
            ld_adr      <= LOAD_BASE;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            ld_en_q <= ld_en;
            if (!ld_en) begin
                byte_cnt <= '0;
            end else if (byte_in && !drop) begin
                ld_asm   <= asm_nx;
                byte_cnt <= byte_cnt + 3'd1;
            end
            if (xfer) ld_hold <= asm_nx;

            if (xfer)          ld_pend <= 1'b1;
            else if (ld_issue) ld_pend <= 1'b0;

            if (ld_rise) begin
                ld_adr   <= LOAD_BASE;
                ld_count <= '0;
            end else if (ld_issue) begin
                ld_adr   <= ld_adr + N'(8);
                ld_count <= ld_count + 16'd1;
            end

            if (ld_rise)   ld_overflow <= 1'b0;
            else if (drop) ld_overflow <= 1'b1;

            if (ld_issue)
                starve_cnt <= '0;
            else if (ld_pend && (starve_cnt < STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         ld_csum <= '0;
        else if (ld_rise)  ld_csum <= '0;
        else if (ld_issue) ld_csum <= ld_csum ^ mem_wdata;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model
// (instance a: LOAD_BASE=0x1000, STARVE_LIMIT=4; instance b: LOAD_BASE=0, STARVE_LIMIT=15).
module tb_mem_port_arbiter;
    localparam int A_LIMIT = 4;
    localparam logic [63:0] A_BASE = 64'h1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_cpu_req, a_cpu_dword, a_cpu_ack, a_cpu_rvalid;
    logic [1:0]  a_cpu_we, a_mem_memwrite;
    logic [63:0] a_cpu_adr, a_cpu_wdata, a_cpu_rdata, a_mem_adr, a_mem_wdata, a_mem_readdata;
    logic        a_ld_en, a_rx_valid, a_ld_overflow, a_mem_memread, a_mem_dword;
    logic [7:0]  a_rx_byte;
    logic [15:0] a_ld_count;

    logic        b_cpu_req, b_cpu_dword, b_cpu_ack, b_cpu_rvalid;
    logic [1:0]  b_cpu_we, b_mem_memwrite;
    logic [63:0] b_cpu_adr, b_cpu_wdata, b_cpu_rdata, b_mem_adr, b_mem_wdata, b_mem_readdata;
    logic        b_ld_en, b_rx_valid, b_ld_overflow, b_mem_memread, b_mem_dword;
    logic [7:0]  b_rx_byte;
    logic [15:0] b_ld_count;
`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
    logic [63:0] a_ld_csum, b_ld_csum;
`endif

    mem_port_arbiter #(.N(64), .LOAD_BASE(A_BASE), .STARVE_LIMIT(A_LIMIT)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_dword(a_cpu_dword),
        .cpu_adr(a_cpu_adr), .cpu_wdata(a_cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
        .ld_en(a_ld_en), .rx_valid(a_rx_valid), .rx_byte(a_rx_byte),
        .ld_count(a_ld_count), .ld_overflow(a_ld_overflow),
`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
        .ld_csum(a_ld_csum),
`endif
        .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata), .mem_memwrite(a_mem_memwrite),
        .mem_memread(a_mem_memread), .mem_dword(a_mem_dword), .mem_readdata(a_mem_readdata)
    );

    mem_port_arbiter #(.N(64), .LOAD_BASE(64'h0), .STARVE_LIMIT(15)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_dword(b_cpu_dword),
        .cpu_adr(b_cpu_adr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .ld_en(b_ld_en), .rx_valid(b_rx_valid), .rx_byte(b_rx_byte),
        .ld_count(b_ld_count), .ld_overflow(b_ld_overflow),
`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
        .ld_csum(b_ld_csum),
`endif
        .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata), .mem_memwrite(b_mem_memwrite),
        .mem_memread(b_mem_memread), .mem_dword(b_mem_dword), .mem_readdata(b_mem_readdata)
    );

    // Memory with registered read data: a fixed value for directed tests, an address hash otherwise.
    logic        use_fixed;
    logic [63:0] fixed_rd;
    function automatic logic [63:0] memf(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3A5_0F1E, a[63:32] ^ 32'h1234_5678};
    endfunction
    always @(posedge clk)
        if (a_mem_memread) a_mem_readdata <= use_fixed ? fixed_rd : memf(a_mem_adr);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    int          ld_at, n_wr, nb, gap, wait_cnt;
    logic        found, done, served, busy, rd_pend, cur_dword;
    logic [1:0]  cur_we;
    logic [63:0] rd_exp, cur_adr, cur_wdata, acc, csum_acc, w;
    logic [63:0] exp_words[$];
    int          due_q[$];

    initial begin
        reset = 1'b1;
        use_fixed = 1'b1; fixed_rd = '0; a_mem_readdata = '0; b_mem_readdata = '0;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_dword = 0; a_cpu_adr = '0; a_cpu_wdata = '0;
        a_ld_en = 0; a_rx_valid = 0; a_rx_byte = '0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_dword = 0; b_cpu_adr = '0; b_cpu_wdata = '0;
        b_ld_en = 0; b_rx_valid = 0; b_rx_byte = '0;
        tick; tick;
        chk("rst_ack", a_cpu_ack, 0);
        chk("rst_rvalid", a_cpu_rvalid, 0);
        chk("rst_memwrite", a_mem_memwrite, 0);
        chk("rst_memread", a_mem_memread, 0);
        chk("rst_adr", a_mem_adr, 0);
        chk("rst_count", a_ld_count, 0);
        reset = 1'b0;
        tick;

        // CPU doubleword store
        a_cpu_req = 1; a_cpu_we = 2'd3; a_cpu_adr = 64'h10; a_cpu_wdata = 64'h1122334455667788;
        tick;
        chk("st_ack", a_cpu_ack, 1);
        chk("st_memwrite", a_mem_memwrite, 3);
        chk("st_adr", a_mem_adr, 64'h10);
        chk("st_wdata", a_mem_wdata, 64'h1122334455667788);
        a_cpu_req = 0;
        tick;
        chk("st_ack_clr", a_cpu_ack, 0);
        chk("st_memwrite_clr", a_mem_memwrite, 0);
        chk("st_adr_hold", a_mem_adr, 64'h10);

        // CPU word load
        fixed_rd = 64'hAABBCCDD;
        a_cpu_req = 1; a_cpu_we = 2'd0; a_cpu_dword = 0; a_cpu_adr = 64'h14;
        tick;
        chk("ld_ack", a_cpu_ack, 1);
        chk("ld_memread", a_mem_memread, 1);
        chk("ld_dword", a_mem_dword, 0);
        chk("ld_adr", a_mem_adr, 64'h14);
        chk("ld_rvalid_early", a_cpu_rvalid, 0);
        a_cpu_req = 0;
        tick;
        chk("ld_rvalid", a_cpu_rvalid, 1);
        chk("ld_rdata", a_cpu_rdata, 64'hAABBCCDD);
        chk("ld_memread_clr", a_mem_memread, 0);
        tick;
        chk("ld_rvalid_clr", a_cpu_rvalid, 0);

        // Loader: two words, uncontested
        a_ld_en = 1;
        tick;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                a_rx_valid = 1; a_rx_byte = 8'(16 * k + i + 1);
                tick;
            end
            a_rx_valid = 0;
            chk("ldr_pend_cycle", a_mem_memwrite, 0);
            tick;
            chk("ldr_memwrite", a_mem_memwrite, 3);
            chk("ldr_adr", a_mem_adr, A_BASE + 64'(8 * k));
            chk("ldr_wdata", a_mem_wdata, (k == 0) ? 64'h0102030405060708 : 64'h1112131415161718);
            tick;
            chk("ldr_count", a_ld_count, 16'(k + 1));
        end

        // Starvation: CPU stores back to back while a loader word waits
        a_cpu_we = 2'd3; a_cpu_adr = 64'h200; a_cpu_wdata = 64'hDEADBEEF00000001; a_cpu_req = 1;
        ld_at = -1; served = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (a_cpu_ack) begin
                if (ld_at >= 0) begin served = 1; done = 1; a_cpu_req = 0; end
                else a_cpu_adr = a_cpu_adr + 64'h8;
            end else if (a_mem_memwrite != 2'd0) begin
                ld_at = i;
                chk("starve_adr", a_mem_adr, A_BASE + 64'h10);
                chk("starve_wdata", a_mem_wdata, 64'h2122232425262728);
            end
            if (i < 8) begin a_rx_valid = 1; a_rx_byte = 8'(8'h21 + i); end
            else a_rx_valid = 0;
            if (!done) tick;
        end
        chk("starve_window", (ld_at >= 8 + A_LIMIT + 1) && (ld_at <= 8 + A_LIMIT + 3), 1);
        chk("starve_cpu_served", served, 1);
        a_cpu_req = 0;
        tick;
        chk("starve_count", a_ld_count, 3);

        // ld_en drop discards a partial word; rise restarts address and count
        for (int i = 0; i < 3; i++) begin
            a_rx_valid = 1; a_rx_byte = 8'(8'hA1 + i);
            tick;
        end
        a_ld_en = 0; a_rx_byte = 8'hEE;
        tick;
        a_rx_valid = 0;
        tick;
        a_ld_en = 1;
        tick;
        chk("lden_count_clr", a_ld_count, 0);
        for (int i = 0; i < 8; i++) begin
            a_rx_valid = 1; a_rx_byte = 8'(8'hB1 + i);
            tick;
        end
        a_rx_valid = 0;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick;
            if (a_mem_memwrite != 2'd0) found = 1;
        end
        chk("lden_found", found, 1);
        chk("lden_adr", a_mem_adr, A_BASE);
        chk("lden_wdata", a_mem_wdata, 64'hB1B2B3B4B5B6B7B8);
        tick;
        chk("lden_count", a_ld_count, 1);

        // Randomized mixed traffic against a transaction-level model
        a_ld_en = 0; tick; a_ld_en = 1; tick;
        use_fixed = 0;
        n_wr = 0; nb = 0; gap = 0; busy = 0; rd_pend = 0; wait_cnt = 0; acc = '0; csum_acc = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_rvalid", a_cpu_rvalid, rd_pend);
            if (rd_pend) chk("rnd_rdata", a_cpu_rdata, rd_exp);
            rd_pend = 0;
            chk("rnd_ld_count", a_ld_count, 16'(n_wr));
            chk("rnd_overflow", a_ld_overflow, 0);
            if (a_cpu_ack) begin
                chk("rnd_ack_req", busy, 1);
                chk("rnd_cpu_adr", a_mem_adr, cur_adr);
                chk("rnd_cpu_we", a_mem_memwrite, cur_we);
                if (cur_we != 2'd0) begin
                    chk("rnd_cpu_wdata", a_mem_wdata, cur_wdata);
                end else begin
                    chk("rnd_cpu_memread", a_mem_memread, 1);
                    chk("rnd_cpu_dword", a_mem_dword, cur_dword);
                    rd_pend = 1; rd_exp = memf(cur_adr);
                end
                busy = 0;
            end else if (a_mem_memwrite != 2'd0 || a_mem_memread) begin
                chk("rnd_ld_cmd", a_mem_memwrite, 3);
                chk("rnd_ld_memread", a_mem_memread, 0);
                chk("rnd_ld_queue", exp_words.size(), 1);
                if (exp_words.size() > 0) begin
                    w = exp_words.pop_front();
                    chk("rnd_ld_adr", a_mem_adr, A_BASE + 64'(8 * n_wr));
                    chk("rnd_ld_wdata", a_mem_wdata, w);
                    chk("rnd_ld_age", (cyc - due_q.pop_front()) <= A_LIMIT + 3, 1);
                    csum_acc = csum_acc ^ w;
                end
                n_wr++;
            end
            if (busy) begin
                wait_cnt++;
                if (wait_cnt > 16) begin
                    chk("rnd_cpu_timeout", wait_cnt, 16);
                    busy = 0;
                end
            end
            if (!busy && cyc < 1400 && $urandom_range(0, 2) == 0) begin
                cur_we = 2'($urandom_range(0, 3));
                cur_dword = 1'($urandom_range(0, 1));
                cur_adr = {$urandom(), $urandom()};
                cur_wdata = {$urandom(), $urandom()};
                a_cpu_we = cur_we; a_cpu_dword = cur_dword;
                a_cpu_adr = cur_adr; a_cpu_wdata = cur_wdata;
                busy = 1; wait_cnt = 0;
            end
            a_cpu_req = busy;
            if (gap > 0 || cyc >= 1400) begin
                if (gap > 0) gap--;
                a_rx_valid = 0;
            end else begin
                a_rx_valid = 1; a_rx_byte = 8'($urandom());
                acc = {acc[55:0], a_rx_byte};
                nb++;
                if (nb == 8) begin
                    exp_words.push_back(acc);
                    due_q.push_back(cyc + 1);
                    nb = 0;
                end
                gap = $urandom_range(1, 3);
            end
            tick;
        end
        chk("rnd_drained", exp_words.size(), 0);
        chk("rnd_cpu_idle", busy, 0);
`ifdef MEM_PORT_ARBITER_CHECKSUM_EN
        chk("rnd_csum", a_ld_csum, csum_acc);
`endif

        // Reset during a read kills the pending rvalid
        a_cpu_req = 1; a_cpu_we = 2'd0; a_cpu_dword = 1; a_cpu_adr = 64'h40;
        tick;
        chk("rstmid_ack", a_cpu_ack, 1);
        a_cpu_req = 0; reset = 1;
        #1;
        chk("rstmid_ack_clr", a_cpu_ack, 0);
        chk("rstmid_memread", a_mem_memread, 0);
        chk("rstmid_adr", a_mem_adr, 0);
        tick;
        chk("rstmid_rvalid", a_cpu_rvalid, 0);
        reset = 0;
        tick;
        chk("rstmid_rvalid2", a_cpu_rvalid, 0);
        chk("rstmid_count", a_ld_count, 0);

        // Overflow on instance b: CPU held, 16 bytes back to back
        b_ld_en = 1;
        tick;
        b_cpu_we = 2'd3; b_cpu_adr = 64'h300; b_cpu_wdata = 64'h5555AAAA5555AAAA; b_cpu_req = 1;
        ld_at = -1; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (i == 15) chk("ovf_before", b_ld_overflow, 0);
            if (i == 16) chk("ovf_set", b_ld_overflow, 1);
            if (b_cpu_ack) begin
                if (ld_at >= 0) begin done = 1; b_cpu_req = 0; end
                else b_cpu_adr = b_cpu_adr + 64'h8;
            end else if (b_mem_memwrite != 2'd0) begin
                ld_at = i;
                chk("ovf_first_adr", b_mem_adr, 0);
                chk("ovf_first_wdata", b_mem_wdata, 64'h0102030405060708);
            end
            if (i < 16) begin b_rx_valid = 1; b_rx_byte = 8'(i + 1); end
            else b_rx_valid = 0;
            if (!done) tick;
        end
        chk("ovf_window", (ld_at >= 24) && (ld_at <= 26), 1);
        chk("ovf_cpu_served", done, 1);
        b_rx_valid = 1; b_rx_byte = 8'h77;
        tick;
        b_rx_valid = 0;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (b_mem_memwrite != 2'd0) found = 1;
            else tick;
        end
        chk("ovf_second_found", found, 1);
        chk("ovf_second_adr", b_mem_adr, 64'h8);
        chk("ovf_second_wdata", b_mem_wdata, 64'h090A0B0C0D0E0F77);
        tick;
        chk("ovf_count", b_ld_count, 2);
        chk("ovf_sticky", b_ld_overflow, 1);
        b_ld_en = 0; tick; b_ld_en = 1; tick;
        chk("ovf_clr", b_ld_overflow, 0);
        chk("ovf_count_clr", b_ld_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
